// File: rtl/cla_adder.sv
// cla_adder: N-bit two-level carry-lookahead adder with a registered result.
// 4-bit lookahead groups feed a tree of 4-wide group-carry lookahead units,
// so no carry ripples between groups at any width.
// Optional feature: define CLA_OVERFLOW_EN to add the registered signed
// overflow output Ovf.
module cla_adder #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         out_valid
`ifdef CLA_OVERFLOW_EN
  ,
  output logic         Ovf
`endif
);

  // Tree sizing: the group count is padded up to a power of 4 so that every
  // lookahead node has exactly four children. Padded groups have g=p=0.
  function automatic int pad_pow4(input int n);
    int r;
    r = 1;
    while (r < n) r = r * 4;
    return r;
  endfunction

  function automatic int levels4(input int n);
    int r;
    int l;
    r = 1;
    l = 0;
    while (r < n) begin
      r = r * 4;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int NG  = N / 4;
  localparam int NGP = pad_pow4(NG);
  localparam int LV  = levels4(NG);

  if ((N % 4) != 0 || N < 4) begin : g_bad_width
    $fatal(1, "cla_adder: N must be a multiple of 4 and at least 4");
  end

  // Carries into positions 0..3 of a 4-wide lookahead block (c[0] = cin).
  function automatic logic [3:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                            input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [N-1:0] bit_g;
  logic [N-1:0] bit_p;
  logic [N-1:0] bit_c;
  logic [N-1:0] sum;
  logic         carry_out;
  // Per tree level: generate, propagate and carry-in of every node.
  // Entry NGP of level 0 carries the root carry-out, so carry_out is always
  // the carry into group NG whether or not the tree is padded.
  logic [NGP:0] lvl_g [LV+1];
  logic [NGP:0] lvl_p [LV+1];
  logic [NGP:0] lvl_c [LV+1];

  // Combinational core: up-sweep of group G/P, down-sweep of carries, sum.
  always_comb begin
    for (int l = 0; l <= LV; l++) begin
      lvl_g[l] = '0;
      lvl_p[l] = '0;
      lvl_c[l] = '0;
    end
    bit_g = A & B;
    bit_p = A ^ B;
    bit_c = '0;

    for (int k = 0; k < NG; k++) begin
      lvl_g[0][k] = group_gen(bit_g[4*k +: 4], bit_p[4*k +: 4]);
      lvl_p[0][k] = &bit_p[4*k +: 4];
    end

    for (int l = 1; l <= LV; l++) begin
      for (int j = 0; j < NGP / 4; j++) begin
        if (j < (NGP >> (2 * l))) begin
          lvl_g[l][j] = group_gen(lvl_g[l-1][4*j +: 4], lvl_p[l-1][4*j +: 4]);
          lvl_p[l][j] = &lvl_p[l-1][4*j +: 4];
        end
      end
    end

    lvl_c[LV][0] = Cin;
    for (int l = LV; l >= 1; l--) begin
      for (int j = 0; j < NGP / 4; j++) begin
        if (j < (NGP >> (2 * l))) begin
          lvl_c[l-1][4*j +: 4] = lookahead4(lvl_g[l-1][4*j +: 4], lvl_p[l-1][4*j +: 4],
                                            lvl_c[l][j]);
        end
      end
    end
    lvl_c[0][NGP] = lvl_g[LV][0] | (lvl_p[LV][0] & Cin);

    for (int k = 0; k < NG; k++) begin
      bit_c[4*k +: 4] = lookahead4(bit_g[4*k +: 4], bit_p[4*k +: 4], lvl_c[0][k]);
    end

    sum       = bit_p ^ bit_c;
    carry_out = lvl_c[0][NG];
  end

  // Result register: loads only on valid input, so idle-cycle operands
  // never reach S/Cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      Ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S    <= sum;
        Cout <= carry_out;
`ifdef CLA_OVERFLOW_EN
        Ovf  <= bit_c[N-1] ^ carry_out;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: directed and randomized checks of cla_adder at N=16 and N=32
// against an arithmetic reference model.
module tb_cla_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v16, ci16, co16, ov16_valid;
  logic [15:0] a16, b16, s16;
  logic        v32, ci32, co32, ov32_valid;
  logic [31:0] a32, b32, s32;
`ifdef CLA_OVERFLOW_EN
  logic        ovf16, ovf32;
`endif

  cla_adder #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .A(a16), .B(b16), .Cin(ci16),
    .S(s16), .Cout(co16), .out_valid(ov16_valid)
`ifdef CLA_OVERFLOW_EN
    , .Ovf(ovf16)
`endif
  );

  cla_adder #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .A(a32), .B(b32), .Cin(ci32),
    .S(s32), .Cout(co32), .out_valid(ov32_valid)
`ifdef CLA_OVERFLOW_EN
    , .Ovf(ovf32)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp16_s;
  logic        exp16_c, exp16_v, exp16_o;
  logic [31:0] exp32_s;
  logic        exp32_c, exp32_v, exp32_o;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed overflow: the true signed sum falls outside the n-bit range.
  function automatic logic ovf_ref(input int n, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci);
    longint sa, sb, t, lim;
    lim = longint'(64'd1 << (n - 1));
    sa  = a[n-1] ? longint'(a) - 2 * lim : longint'(a);
    sb  = b[n-1] ? longint'(b) - 2 * lim : longint'(b);
    t   = sa + sb + longint'(ci);
    return (t >= lim) || (t < -lim);
  endfunction

  task automatic apply16(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ci);
    logic [16:0] full;
    v16 = v; a16 = a; b16 = b; ci16 = ci;
    exp16_v = v;
    if (v) begin
      full    = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      exp16_s = full[15:0];
      exp16_c = full[16];
      exp16_o = ovf_ref(16, {48'd0, a}, {48'd0, b}, ci);
    end
  endtask

  task automatic apply32(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic ci);
    logic [32:0] full;
    v32 = v; a32 = a; b32 = b; ci32 = ci;
    exp32_v = v;
    if (v) begin
      full    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      exp32_s = full[31:0];
      exp32_c = full[32];
      exp32_o = ovf_ref(32, {32'd0, a}, {32'd0, b}, ci);
    end
  endtask

  task automatic clear_model();
    exp16_s = '0; exp16_c = 1'b0; exp16_v = 1'b0; exp16_o = 1'b0;
    exp32_s = '0; exp32_c = 1'b0; exp32_v = 1'b0; exp32_o = 1'b0;
  endtask

  task automatic check16(input string tag);
    check({tag, ".S16"}, {48'd0, s16}, {48'd0, exp16_s});
    check({tag, ".Cout16"}, {63'd0, co16}, {63'd0, exp16_c});
    check({tag, ".valid16"}, {63'd0, ov16_valid}, {63'd0, exp16_v});
`ifdef CLA_OVERFLOW_EN
    check({tag, ".Ovf16"}, {63'd0, ovf16}, {63'd0, exp16_o});
`endif
  endtask

  task automatic check32(input string tag);
    check({tag, ".S32"}, {32'd0, s32}, {32'd0, exp32_s});
    check({tag, ".Cout32"}, {63'd0, co32}, {63'd0, exp32_c});
    check({tag, ".valid32"}, {63'd0, ov32_valid}, {63'd0, exp32_v});
`ifdef CLA_OVERFLOW_EN
    check({tag, ".Ovf32"}, {63'd0, ovf32}, {63'd0, exp32_o});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand(input int n);
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0:       r = '1;
      1:       r = '0;
      2:       r = 32'h1 << (n - 1);
      default: r = $urandom();
    endcase
    if (n == 16) r[31:16] = '0;
    return r;
  endfunction

  initial begin
    clear_model();
    v16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0;

    #12;
    check16("reset");
    check32("reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply16(1'b1, 16'd1, 16'd2, 1'b0);
    step(); check16("add_1_2");
    apply16(1'b1, 16'd5, 16'd4, 1'b1);
    step(); check16("add_5_4_cin");
    apply16(1'b0, 16'hA5A5, 16'h5A5A, 1'b1);
    step(); check16("idle_hold");
    apply16(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    step(); check16("wrap_ffff_ffff");
    apply16(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    step(); check16("chain_ffff_0_cin");
    apply16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step(); check16("max_result");

    apply16(1'b1, 16'h1234, 16'h1111, 1'b0);
    step(); check16("b2b_0");
    apply16(1'b1, 16'h8001, 16'h7FFF, 1'b0);
    step(); check16("b2b_1");
    apply16(1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
    step(); check16("b2b_2");
    apply16(1'b0, 16'h0, 16'h0, 1'b0);
    step(); check16("b2b_idle");

`ifdef CLA_OVERFLOW_EN
    apply16(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    step(); check16("ovf_pos");
    apply16(1'b1, 16'h8000, 16'h8000, 1'b0);
    step(); check16("ovf_neg");
    apply16(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    step(); check16("ovf_none");
`endif

    // Asynchronous reset between edges discards the held and pending results.
    apply16(1'b1, 16'h4321, 16'h1234, 1'b1);
    apply32(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    step(); check16("pre_reset"); check32("pre_reset");
    apply16(1'b1, 16'h1111, 16'h2222, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check16("async_reset"); check32("async_reset");
    step(); check16("reset_held"); check32("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    apply32(1'b0, 32'd0, 32'd0, 1'b0);
    apply16(1'b1, 16'h0102, 16'h0304, 1'b0);
    step(); check16("post_reset"); check32("post_reset");

    for (int i = 0; i < 10000; i++) begin
      apply16(($urandom_range(0, 3) != 0), 16'(rand_operand(16)), 16'(rand_operand(16)),
              1'($urandom_range(0, 1)));
      apply32(($urandom_range(0, 3) != 0), rand_operand(32), rand_operand(32),
              1'($urandom_range(0, 1)));
      step();
      check16("rand");
      check32("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
